wisard_stream_gen: RTL and testbench

WISARD_STREAM_GEN -- requirements
Module: wisard_stream_gen

---
 rtl/wisard_pkg.sv | 13 +
 rtl/wisard_beat_counter.sv | 39 +++
 rtl/wisard_stream_gen.sv | 78 +++++++
 tb/tb_wisard_stream_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisard_pkg.sv
// Shared constants and FSM state type for the WiSARD address stream generator.
package wisard_pkg;

    localparam int unsigned DEF_INDEX_WIDTH = 5;
    localparam int unsigned DEF_N_RAMS      = 27;
    localparam int unsigned DEF_ADDR_WIDTH  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/wisard_beat_counter.sv
// Beat index counter: clear has priority over enable; last flags index N_RAMS-1.
module wisard_beat_counter
    import wisard_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int unsigned N_RAMS      = DEF_N_RAMS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   clr_i,
    output logic [INDEX_WIDTH-1:0] index_o,
    output logic                   last_o
);

    logic [INDEX_WIDTH-1:0] index_q;
    logic [INDEX_WIDTH-1:0] index_d;

    always_comb begin
        index_d = index_q;
        if (clr_i) begin
            index_d = '0;
        end else if (en_i) begin
            index_d = index_q + INDEX_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q <= '0;
        end else begin
            index_q <= index_d;
        end
    end

    assign index_o = index_q;
    assign last_o  = (index_q == INDEX_WIDTH'(N_RAMS - 1));

endmodule

// File: rtl/wisard_stream_gen.sv
// Serialises one packed WiSARD sample into N_RAMS address beats with sop/eop/index,
// accepting the next sample on the last-beat handshake so streams run back-to-back.
module wisard_stream_gen
    import wisard_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int unsigned N_RAMS      = DEF_N_RAMS,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_RAMS*ADDR_WIDTH-1:0] in_data,
    output logic                         src_valid,
    input  logic                         src_ready,
    output logic [ADDR_WIDTH-1:0]        src_data,
    output logic                         sop,
    output logic                         eop,
    output logic [INDEX_WIDTH-1:0]       index
);

    localparam int unsigned DATA_W = N_RAMS * ADDR_WIDTH;

    state_t              state_q;
    logic [DATA_W-1:0]   hold_q;
    logic                last;
    logic                beat_hs;
    logic                last_hs;
    logic                accept;

    assign src_valid = (state_q == SEND);
    assign beat_hs   = src_valid & src_ready;
    assign last_hs   = beat_hs & last;
    // Gated by rst so no sample is offered acceptance while reset is held.
    assign in_ready  = ~rst & ((state_q == IDLE) | last_hs);
    assign accept    = in_valid & in_ready;

    wisard_beat_counter #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .N_RAMS      (N_RAMS)
    ) u_beat_counter (
        .clk     (clk),
        .rst     (rst),
        .en_i    (beat_hs),
        .clr_i   (accept | last_hs),
        .index_o (index),
        .last_o  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            if (accept) begin
                hold_q  <= in_data;
                state_q <= SEND;
            end else if (last_hs) begin
                state_q <= IDLE;
            end
        end
    end

    // Beat select from the holding register, aligned with the current index.
    always_comb begin
        src_data = '0;
        for (int unsigned k = 0; k < N_RAMS; k++) begin
            if (index == INDEX_WIDTH'(k)) begin
                src_data = hold_q[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign sop = src_valid & (index == '0);
    assign eop = src_valid & last;

endmodule

// File: tb/tb_wisard_stream_gen.sv
// Scoreboard bench for wisard_stream_gen: directed samples, expected beats queued, monitor compares.
module tb_wisard_stream_gen;

    localparam int N  = 27;
    localparam int AW = 8;
    localparam int IW = 5;

    typedef struct packed {
        logic [AW-1:0] data;
        logic [IW-1:0] idx;
        logic          sop;
        logic          eop;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*AW-1:0] in_data;
    logic            src_valid;
    logic            src_ready;
    logic [AW-1:0]   src_data;
    logic            sop;
    logic            eop;
    logic [IW-1:0]   index;

    logic            in_valid1;
    logic            in_ready1;
    logic [AW-1:0]   in_data1;
    logic            src_valid1;
    logic            src_ready1;
    logic [AW-1:0]   src_data1;
    logic            sop1;
    logic            eop1;
    logic [IW-1:0]   index1;

    beat_t         exp_q[$];
    int            checks   = 0;
    int            errors   = 0;
    int            hs_count = 0;
    logic [IW-1:0] rx_idx   = '0;

    always #5 clk = ~clk;

    wisard_stream_gen #(.INDEX_WIDTH(IW), .N_RAMS(N), .ADDR_WIDTH(AW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_data  (src_data),
        .sop       (sop),
        .eop       (eop),
        .index     (index)
    );

    wisard_stream_gen #(.INDEX_WIDTH(IW), .N_RAMS(1), .ADDR_WIDTH(AW)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .src_valid (src_valid1),
        .src_ready (src_ready1),
        .src_data  (src_data1),
        .sop       (sop1),
        .eop       (eop1),
        .index     (index1)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [N*AW-1:0] mk(input logic [AW-1:0] base);
        logic [N*AW-1:0] r;
        for (int k = 0; k < N; k++) r[k*AW +: AW] = base + AW'(k);
        return r;
    endfunction

    task automatic push_sample(input logic [AW-1:0] base);
        beat_t b;
        for (int k = 0; k < N; k++) begin
            b.data = base + AW'(k);
            b.idx  = IW'(k);
            b.sop  = (k == 0);
            b.eop  = (k == N - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic send(input logic [N*AW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(output int cyc);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    // Monitor: scoreboard pop plus an independent receiver-side index counter.
    task automatic monitor();
        beat_t got;
        beat_t e;
        forever begin
            @(negedge clk);
            if (src_valid && src_ready) begin
                got = {src_data, index, sop, eop};
                hs_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(got), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(got), 64'(e));
                end
                check("rx_index", 64'(index), 64'(rx_idx));
                check("rx_eop", 64'(eop), 64'(rx_idx == IW'(N - 1)));
                rx_idx = (rx_idx == IW'(N - 1)) ? '0 : rx_idx + IW'(1);
            end
        end
    endtask

    task automatic stimulus();
        int cyc;
        int pulses;
        int pos;

        // Reset state of both instances
        #12;
        check("rst_state", 64'({src_valid, sop, eop, in_ready, index, src_data}), 64'(0));
        check("rst_state_n1", 64'({src_valid1, sop1, eop1, in_ready1, index1, src_data1}), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready), 64'(1));
        src_ready = 1'b1;

        // Single sample, beats k+1, continuous ready
        @(posedge clk);
        #1;
        push_sample(8'd1);
        send(mk(8'd1));
        @(negedge clk);
        check("first_beat_latency", 64'({src_valid, sop, index}), 64'({1'b1, 1'b1, IW'(0)}));
        drain(cyc);
        check("single_cycles", 64'(cyc), 64'(27));
        @(negedge clk);
        check("single_idle", 64'(src_valid), 64'(0));

        // Back-to-back samples with in_valid held
        @(posedge clk);
        #1;
        push_sample(8'h40);
        push_sample(8'h80);
        in_valid = 1'b1;
        in_data  = mk(8'h40);
        @(posedge clk);
        #1 in_data = mk(8'h80);
        pulses = 0;
        pos    = -1;
        for (int j = 0; j < N; j++) begin
            @(negedge clk);
            if (in_ready) begin
                pulses++;
                pos = j;
            end
        end
        check("b2b_inready_pulses", 64'(pulses), 64'(1));
        check("b2b_inready_pos", 64'(pos), 64'(26));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("b2b_no_gap", 64'({src_valid, sop, index}), 64'({1'b1, 1'b1, IW'(0)}));
        drain(cyc);
        @(negedge clk);
        check("b2b_idle", 64'(src_valid), 64'(0));

        // Stall at index 5 for two cycles
        @(posedge clk);
        #1;
        hs_count = 0;
        push_sample(8'h10);
        send(mk(8'h10));
        repeat (5) @(posedge clk);
        #1 src_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check("stall_hold", 64'({index, src_data, sop, eop}), 64'({IW'(5), 8'h15, 1'b0, 1'b0}));
        end
        @(posedge clk);
        #1 src_ready = 1'b1;
        @(negedge clk);
        check("stall_hold_release", 64'({index, src_data, sop, eop}), 64'({IW'(5), 8'h15, 1'b0, 1'b0}));
        drain(cyc);
        @(negedge clk);
        check("stall_handshakes", 64'(hs_count), 64'(27));

        // Reset mid-sample at index 10, then a fresh sample
        @(posedge clk);
        #1;
        push_sample(8'h60);
        send(mk(8'h60));
        repeat (10) @(posedge clk);
        #1 check("pre_rst_index", 64'(index), 64'(10));
        #1 rst = 1'b1;
        #1 check("rst_async", 64'({src_valid, sop, eop, in_ready, index, src_data}), 64'(0));
        exp_q.delete();
        rx_idx = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        push_sample(8'hA0);
        send(mk(8'hA0));
        drain(cyc);
        @(negedge clk);
        check("post_rst_idle", 64'(src_valid), 64'(0));

        // Single-beat configuration
        @(posedge clk);
        #1;
        in_valid1  = 1'b1;
        in_data1   = 8'hA5;
        src_ready1 = 1'b1;
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        @(negedge clk);
        check("n1_beat", 64'({src_valid1, sop1, eop1, index1, src_data1}),
              64'({1'b1, 1'b1, 1'b1, IW'(0), 8'hA5}));
        check("n1_in_ready", 64'(in_ready1), 64'(1));
        @(negedge clk);
        check("n1_idle", 64'(src_valid1), 64'(0));
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        src_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_data1   = '0;
        src_ready1 = 1'b0;
        fork
            monitor();
            stimulus();
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
